// File: rtl/hazard_tracker.sv
// hazard_tracker
//   Producer side of the forwarding interface for the 5-stage core. Keeps a
//   {rd, we, memread, memop} record for every instruction past decode
//   (IDEX -> EXMEM -> MEMWB -> PREV), inserts bubbles on load-use hazards
//   and taken-branch flushes, and freezes the records while data memory
//   is busy.
//
//   Optional feature: define HAZ_PREV_STAGE_EN to keep the PREV record
//   (one stage past writeback). Without it prevdestreg_1 reads 31 and
//   prevWE_1 reads 0.
//
//   Ports
//     clk, reset_n                 pipeline clock, async active-low reset
//     id_*                         decoded fields of the instruction in ID
//     flush                        taken branch, squash instruction entering EX
//     mem_ready                    data memory finishes its access this cycle
//     IDEX*/EXMEM*/MEMWB*/prev*    registered destination/write-enable records
//     stall, bubble                combinational pipeline control
//     stall_count                  saturating count of stall cycles
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | normal flow; records shift every edge unless a freeze starts
//   MEM_WAIT | data memory busy; records hold until mem_ready

module hazard_tracker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memop,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             flush,
    input  logic             mem_ready,
    output logic [4:0]       IDEXrd,
    output logic [4:0]       EXMEMrd,
    output logic [4:0]       MEMWBrd,
    output logic [4:0]       prevdestreg_1,
    output logic             IDEXregwrite,
    output logic             EXMEMregwrite,
    output logic             MEMWBregwrite,
    output logic             prevWE_1,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       memread;
        logic       memop;
    } rec_t;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    localparam rec_t BUBBLE_REC = '{rd: 5'd31, we: 1'b0, memread: 1'b0, memop: 1'b0};

    state_t            state_q, state_d;
    rec_t              idex_q, idex_d;
    rec_t              exmem_q, exmem_d;
    rec_t              memwb_q, memwb_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    rec_t              id_rec;
    logic              frozen;
    logic              load_use;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:      if (exmem_q.memop && !mem_ready) state_d = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_ready)                   state_d = S_RUN;
            default:                                     state_d = S_RUN;
        endcase
    end

    // ---------------- outputs ----------------
    // XZR (r31) never creates a hazard, so the compare excludes it.
    always_comb begin
        load_use = idex_q.memread && idex_q.we && (idex_q.rd != 5'd31) &&
                   ((id_uses_rn && (id_rn == idex_q.rd)) ||
                    (id_uses_rm && (id_rm == idex_q.rd)));
    end

    // The mem_ready cycle of MEM_WAIT is not frozen: records shift on that
    // edge, so flush and load-use are honoured there exactly as in RUN.
    always_comb begin
        frozen = 1'b0;
        stall  = 1'b0;
        bubble = 1'b0;
        case (state_q)
            S_RUN:      frozen = exmem_q.memop && !mem_ready;
            S_MEM_WAIT: frozen = !mem_ready;
            default:    frozen = 1'b0;
        endcase
        if (frozen) begin
            stall = 1'b1;
        end else if (flush) begin
            bubble = 1'b1;
        end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end
    end

    // ---------------- record pipeline ----------------
    always_comb begin
        id_rec  = '{rd: id_rd, we: id_regwrite & id_valid,
                    memread: id_memread & id_valid, memop: id_memop & id_valid};
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        if (!frozen) begin
            idex_d  = bubble ? BUBBLE_REC : id_rec;
            exmem_d = idex_q;
            memwb_d = exmem_q;
        end
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_q        <= BUBBLE_REC;
            exmem_q       <= BUBBLE_REC;
            memwb_q       <= BUBBLE_REC;
            stall_count_q <= '0;
        end else begin
            idex_q        <= idex_d;
            exmem_q       <= exmem_d;
            memwb_q       <= memwb_d;
            stall_count_q <= stall_count_d;
        end
    end

`ifdef HAZ_PREV_STAGE_EN
    rec_t prev_q, prev_d;

    always_comb begin
        prev_d = frozen ? prev_q : memwb_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= BUBBLE_REC;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign prevdestreg_1 = prev_q.rd;
    assign prevWE_1      = prev_q.we;

    // Memory-type bits are not needed once an instruction has left MEM.
    logic unused_rec_bits;
    assign unused_rec_bits = ^{prev_q.memread, prev_q.memop};
`else
    // Register-file write-through covers the post-writeback case.
    assign prevdestreg_1 = 5'd31;
    assign prevWE_1      = 1'b0;

    logic unused_rec_bits;
    assign unused_rec_bits = ^{memwb_q.memread, memwb_q.memop};
`endif

    assign IDEXrd        = idex_q.rd;
    assign IDEXregwrite  = idex_q.we;
    assign EXMEMrd       = exmem_q.rd;
    assign EXMEMregwrite = exmem_q.we;
    assign MEMWBrd       = memwb_q.rd;
    assign MEMWBregwrite = memwb_q.we;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_hazard_tracker.sv
module tb_hazard_tracker;

    localparam int CW  = 4;                 // small width so saturation is reachable
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, id_memop = 1'b0;
    logic [4:0]    id_rd = 5'd0, id_rn = 5'd0, id_rm = 5'd0;
    logic          id_uses_rn = 1'b0, id_uses_rm = 1'b0, flush = 1'b0, mem_ready = 1'b1;
    logic [4:0]    IDEXrd, EXMEMrd, MEMWBrd, prevdestreg_1;
    logic          IDEXregwrite, EXMEMregwrite, MEMWBregwrite, prevWE_1;
    logic          stall, bubble;
    logic [CW-1:0] stall_count;

    hazard_tracker #(.CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memop(id_memop),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .flush(flush), .mem_ready(mem_ready),
        .IDEXrd(IDEXrd), .EXMEMrd(EXMEMrd), .MEMWBrd(MEMWBrd), .prevdestreg_1(prevdestreg_1),
        .IDEXregwrite(IDEXregwrite), .EXMEMregwrite(EXMEMregwrite),
        .MEMWBregwrite(MEMWBregwrite), .prevWE_1(prevWE_1),
        .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: pipe[0]=IDEX .. pipe[3]=PREV, plus a "memory busy" flag.
    int  m_rd[4];
    bit  m_we[4], m_mr[4], m_mo[4];
    bit  m_busy;
    int  m_cnt;
    bit  e_stall, e_bubble, e_hold;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_rd[i] = 31; m_we[i] = 0; m_mr[i] = 0; m_mo[i] = 0;
        end
        m_busy = 0;
        m_cnt  = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = m_mr[0] && m_we[0] && (m_rd[0] != 31) &&
             ((id_uses_rn && (int'(id_rn) == m_rd[0])) || (id_uses_rm && (int'(id_rm) == m_rd[0])));
        e_hold   = !mem_ready && (m_busy || m_mo[1]);
        e_stall  = e_hold || (!flush && lu);
        e_bubble = !e_hold && (flush || lu);
    endtask

    task automatic model_edge();
        if (e_stall && m_cnt < SAT) m_cnt++;
        if (e_hold) begin
            m_busy = 1;
        end else begin
            m_busy = 0;
            for (int i = 3; i > 0; i--) begin
                m_rd[i] = m_rd[i-1]; m_we[i] = m_we[i-1]; m_mr[i] = m_mr[i-1]; m_mo[i] = m_mo[i-1];
            end
            if (e_bubble) begin
                m_rd[0] = 31; m_we[0] = 0; m_mr[0] = 0; m_mo[0] = 0;
            end else begin
                m_rd[0] = id_rd;
                m_we[0] = id_regwrite & id_valid;
                m_mr[0] = id_memread & id_valid;
                m_mo[0] = id_memop & id_valid;
            end
        end
    endtask

    // Called at a negedge after inputs are driven: compare everything.
    task automatic settle();
        #1;
        model_eval();
        chk("IDEXrd",        IDEXrd,        m_rd[0]);
        chk("IDEXregwrite",  IDEXregwrite,  m_we[0]);
        chk("EXMEMrd",       EXMEMrd,       m_rd[1]);
        chk("EXMEMregwrite", EXMEMregwrite, m_we[1]);
        chk("MEMWBrd",       MEMWBrd,       m_rd[2]);
        chk("MEMWBregwrite", MEMWBregwrite, m_we[2]);
`ifdef HAZ_PREV_STAGE_EN
        chk("prevdestreg_1", prevdestreg_1, m_rd[3]);
        chk("prevWE_1",      prevWE_1,      m_we[3]);
`else
        chk("prevdestreg_1", prevdestreg_1, 31);
        chk("prevWE_1",      prevWE_1,      0);
`endif
        chk("stall",         stall,         e_stall);
        chk("bubble",        bubble,        e_bubble);
        chk("stall_count",   stall_count,   m_cnt);
    endtask

    task automatic clock();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int rd, input bit rw, input bit mr, input bit mo,
                         input int rn, input bit urn, input int rm, input bit urm,
                         input bit fl, input bit rdy);
        id_valid = v; id_rd = 5'(rd); id_regwrite = rw; id_memread = mr; id_memop = mo;
        id_rn = 5'(rn); id_uses_rn = urn; id_rm = 5'(rm); id_uses_rm = urm;
        flush = fl; mem_ready = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_IDEXrd"},  IDEXrd, 31);
        chk({tag, "_EXMEMrd"}, EXMEMrd, 31);
        chk({tag, "_MEMWBrd"}, MEMWBrd, 31);
        chk({tag, "_prevrd"},  prevdestreg_1, 31);
        chk({tag, "_we"},      {IDEXregwrite, EXMEMregwrite, MEMWBregwrite, prevWE_1}, 0);
        chk({tag, "_stall"},   stall, 0);
        chk({tag, "_bubble"},  bubble, 0);
        chk({tag, "_count"},   stall_count, 0);
    endtask

    int rnd_rd;
    int c0;

    initial begin
        model_reset();
        idle();
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // ADD X3 travels through every record
        drive(1, 3, 1, 0, 0, 1, 1, 2, 1, 0, 1);
        settle(); clock();
        chk("add_idex", IDEXrd, 3);
        idle(); settle(); clock();
        chk("add_exmem", EXMEMrd, 3);
        idle(); settle(); clock();
        chk("add_memwb", MEMWBrd, 3);
        idle(); settle(); clock();
`ifdef HAZ_PREV_STAGE_EN
        chk("add_prev", prevdestreg_1, 3);
`else
        chk("add_prev_off", prevdestreg_1, 31);
`endif

        // load-use: LDUR X5 then reader of X5
        drive(1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        settle(); clock();
        drive(1, 6, 1, 0, 0, 5, 1, 1, 1, 0, 1);
        settle();
        chk("lu_stall", stall, 1);
        chk("lu_bubble", bubble, 1);
        clock();
        settle();
        chk("lu_idex_we", IDEXregwrite, 0);
        chk("lu_stall_after", stall, 0);
        chk("lu_count", stall_count, 1);
        clock();
        chk("lu_dep_in_ex", IDEXrd, 6);
        chk("lu_load_in_wb", MEMWBrd, 5);

        // load to XZR followed by a reader of XZR: no hazard
        drive(1, 31, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        settle(); clock();
        drive(1, 4, 1, 0, 0, 31, 1, 31, 1, 0, 1);
        settle();
        chk("xzr_stall", stall, 0);
        clock();

        // flush overrides a simultaneous load-use
        drive(1, 9, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        settle(); clock();
        drive(1, 7, 1, 0, 0, 9, 1, 0, 0, 1, 1);
        settle();
        chk("flush_stall", stall, 0);
        chk("flush_bubble", bubble, 1);
        clock();
        chk("flush_idexrd", IDEXrd, 31);
        chk("flush_idexwe", IDEXregwrite, 0);

        // store in EXMEM, memory busy for three cycles
        drive(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        settle(); clock();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        settle(); clock();
        c0 = m_cnt;
        for (int k = 0; k < 3; k++) begin
            drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0);   // flush ignored while frozen
            settle();
            chk("frz_stall", stall, 1);
            chk("frz_bubble", bubble, 0);
            clock();
            chk("frz_idex_hold", IDEXrd, 4);
            chk("frz_exmem_hold", EXMEMrd, 2);
        end
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        settle();
        chk("frz_release_stall", stall, 0);
        clock();
        chk("frz_shift_exmem", EXMEMrd, 4);
        chk("frz_shift_idex", IDEXrd, 8);
        chk("frz_count", stall_count, c0 + 3);

        // reset in the middle of a freeze
        drive(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        settle(); clock();
        idle(); settle(); clock();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); clock();                     // now waiting on memory
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_frz");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); clock();
        chk("rst_first_load", IDEXrd, 12);

        // randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            rnd_rd = $urandom_range(0, 8);
            id_valid    = ($urandom_range(0, 7) != 0);
            id_rd       = (rnd_rd == 8) ? 5'd31 : 5'(rnd_rd);
            id_regwrite = $urandom_range(0, 3) != 0;
            id_memread  = $urandom_range(0, 9) < 3;
            id_memop    = id_memread | ($urandom_range(0, 9) < 2);
            id_rn       = ($urandom_range(0, 1) == 1) ? 5'(m_rd[0]) : 5'($urandom_range(0, 31));
            id_rm       = ($urandom_range(0, 3) == 0) ? 5'(m_rd[0]) : 5'($urandom_range(0, 31));
            id_uses_rn  = $urandom_range(0, 3) != 0;
            id_uses_rm  = $urandom_range(0, 1) != 0;
            flush       = $urandom_range(0, 9) == 0;
            mem_ready   = $urandom_range(0, 3) != 0;
            settle();
            clock();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
